rv32i_csr_irq_unit: RTL

Parametrised successor to the single-stage RV32I machine-mode CSR/trap block. Adds N platform-local interrupt lines (mip/mie bits 16+), vectored mtvec mode, 64-bit mcycle/minstret, and a registered CSR read port. Sits beside the execute stage: it consumes decoded CSR/system-instruction flags and the current PC, and drives trap-entry and trap-return redirects into the fetch stage.

---
 rtl/rv32i_csr_pkg.sv | 39 +++
 rtl/rv32i_csr_counter.sv | 20 ++
 rtl/rv32i_csr_irq_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_csr_pkg.sv
// rtl/rv32i_csr_pkg.sv - shared CSR addresses, cause codes and CSR op encodings
package rv32i_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  localparam logic [4:0] EXC_ILLEGAL    = 5'd2;
  localparam logic [4:0] EXC_BREAKPOINT = 5'd3;
  localparam logic [4:0] EXC_ECALL_M    = 5'd11;
  localparam logic [4:0] IRQ_MSI        = 5'd3;
  localparam logic [4:0] IRQ_MTI        = 5'd7;
  localparam logic [4:0] IRQ_MEI        = 5'd11;
  localparam logic [4:0] IRQ_LOCAL_BASE = 5'd16;

  typedef enum logic [2:0] {
    CSR_OP_NONE = 3'b000,
    CSR_OP_RW   = 3'b001,
    CSR_OP_RS   = 3'b010,
    CSR_OP_RC   = 3'b011,
    CSR_OP_RWI  = 3'b101,
    CSR_OP_RSI  = 3'b110,
    CSR_OP_RCI  = 3'b111
  } csr_op_e;

endpackage

// File: rtl/rv32i_csr_counter.sv
// rtl/rv32i_csr_counter.sv - 64-bit counter with increment enable and 32-bit half write ports
module rv32i_csr_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  // a write to either half replaces the whole-counter increment for that cycle
  always_ff @(posedge clk) begin
    if (rst)        count <= 64'd0;
    else if (we_lo) count[31:0] <= wdata;
    else if (we_hi) count[63:32] <= wdata;
    else if (inc)   count <= count + 64'd1;
  end

endmodule

// File: rtl/rv32i_csr_irq_unit.sv
// rtl/rv32i_csr_irq_unit.sv - machine-mode CSR file, trap/interrupt unit; CSR_COUNTERS_EN adds mcycle/minstret
module rv32i_csr_irq_unit
  import rv32i_csr_pkg::*;
#(
  parameter int          NUM_LOCAL_IRQ = 4,
  parameter logic [31:0] RESET_MTVEC   = 32'h0000_0000,
  localparam int         LW            = (NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_ce,
  input  logic          i_stall,
  input  logic          i_external_interrupt,
  input  logic          i_software_interrupt,
  input  logic          i_timer_interrupt,
  input  logic [LW-1:0] i_local_irq,
  input  logic          i_is_inst_illegal,
  input  logic          i_is_ecall,
  input  logic          i_is_ebreak,
  input  logic          i_is_mret,
  input  logic          i_instret,
  input  logic [31:0]   i_pc,
  input  logic [31:0]   i_rs1,
  input  logic [31:0]   i_imm,
  input  logic [2:0]    i_funct3,
  input  logic [11:0]   i_csr_index,
  output logic [31:0]   o_csr_out,
  output logic [31:0]   o_return_address,
  output logic [31:0]   o_trap_address,
  output logic          o_go_to_trap_q,
  output logic          o_return_from_trap_q
);

  localparam logic [31:0] LOCAL_MASK = ((32'h1 << NUM_LOCAL_IRQ) - 32'h1) << 16;
  localparam logic [31:0] MIE_MASK   = 32'h0000_0888 | LOCAL_MASK;

  logic        commit, trap, trap_is_irq, mret, exc_valid, irq_pending, has_op, csr_we;
  logic        mstatus_mie, mstatus_mpie;
  logic [4:0]  exc_cause, irq_cause, trap_cause;
  logic [31:0] mie_q, mip_q, mip_next, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [31:0] pending, src, rdata, wdata, mtvec_base, trap_target;
  csr_op_e     op;

  assign commit      = i_ce && !i_stall;
  assign pending     = mip_q & mie_q;
  assign irq_pending = mstatus_mie && (|pending);
  assign exc_valid   = i_is_inst_illegal || i_is_ecall || i_is_ebreak;
  assign exc_cause   = i_is_inst_illegal ? EXC_ILLEGAL : (i_is_ebreak ? EXC_BREAKPOINT : EXC_ECALL_M);
  assign trap        = commit && (exc_valid || irq_pending);
  assign trap_is_irq = !exc_valid;
  assign trap_cause  = exc_valid ? exc_cause : irq_cause;
  assign mret        = commit && !trap && i_is_mret;
  assign mtvec_base  = {mtvec_q[31:2], 2'b00};
  assign trap_target = (mtvec_q[0] && trap_is_irq) ? mtvec_base + {25'd0, trap_cause, 2'b00} : mtvec_base;
  assign o_return_address = mepc_q;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;
  logic        unused_ok;
  assign unused_ok = ^{i_imm[31:5], i_pc[1:0], i_local_irq};

  rv32i_csr_counter u_mcycle (
    .clk(i_clk), .rst(i_rst), .inc(1'b1),
    .we_lo(csr_we && i_csr_index == CSR_MCYCLE), .we_hi(csr_we && i_csr_index == CSR_MCYCLEH),
    .wdata(wdata), .count(mcycle)
  );

  rv32i_csr_counter u_minstret (
    .clk(i_clk), .rst(i_rst), .inc(i_instret),
    .we_lo(csr_we && i_csr_index == CSR_MINSTRET), .we_hi(csr_we && i_csr_index == CSR_MINSTRETH),
    .wdata(wdata), .count(minstret)
  );
`else
  logic unused_ok;
  assign unused_ok = ^{i_imm[31:5], i_pc[1:0], i_local_irq, i_instret};
`endif

  // raw interrupt lines mapped onto their mip bit positions
  always_comb begin
    mip_next     = 32'd0;
    mip_next[11] = i_external_interrupt;
    mip_next[7]  = i_timer_interrupt;
    mip_next[3]  = i_software_interrupt;
    for (int k = 0; k < NUM_LOCAL_IRQ; k++) mip_next[16+k] = i_local_irq[k];
  end

  // highest-priority pending interrupt: later assignments win, so MEI is last
  always_comb begin
    irq_cause = 5'd0;
    for (int k = NUM_LOCAL_IRQ - 1; k >= 0; k--)
      if (pending[16+k]) irq_cause = IRQ_LOCAL_BASE + 5'(k);
    if (pending[7])  irq_cause = IRQ_MTI;
    if (pending[3])  irq_cause = IRQ_MSI;
    if (pending[11]) irq_cause = IRQ_MEI;
  end

  // CSR read mux; unimplemented addresses read zero
  always_comb begin
    rdata = 32'd0;
    case (i_csr_index)
      CSR_MSTATUS:   rdata = {19'd0, 2'b11, 3'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
      CSR_MISA:      rdata = MISA_VALUE;
      CSR_MIE:       rdata = mie_q;
      CSR_MIP:       rdata = mip_q;
      CSR_MTVEC:     rdata = mtvec_q;
      CSR_MSCRATCH:  rdata = mscratch_q;
      CSR_MEPC:      rdata = mepc_q;
      CSR_MCAUSE:    rdata = mcause_q;
      CSR_MTVAL:     rdata = mtval_q;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    rdata = mcycle[31:0];
      CSR_MCYCLEH:   rdata = mcycle[63:32];
      CSR_MINSTRET:  rdata = minstret[31:0];
      CSR_MINSTRETH: rdata = minstret[63:32];
`endif
      default:       rdata = 32'd0;
    endcase
  end

  // write value per op; set/clear with a zero source is a pure read
  always_comb begin
    op     = csr_op_e'(i_funct3);
    src    = i_funct3[2] ? {27'd0, i_imm[4:0]} : i_rs1;
    wdata  = src;
    has_op = 1'b0;
    case (op)
      CSR_OP_RW, CSR_OP_RWI: begin has_op = 1'b1;          wdata = src;          end
      CSR_OP_RS, CSR_OP_RSI: begin has_op = (src != 0);    wdata = rdata | src;  end
      CSR_OP_RC, CSR_OP_RCI: begin has_op = (src != 0);    wdata = rdata & ~src; end
      default:               begin has_op = 1'b0;          wdata = src;          end
    endcase
  end

  assign csr_we = commit && !trap && has_op;

  // interrupt inputs are sampled one cycle before they can be taken
  always_ff @(posedge i_clk) begin
    if (i_rst) mip_q <= 32'd0;
    else       mip_q <= mip_next;
  end

  // mstatus: trap entry beats MRET beats a software write
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (trap) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (csr_we && i_csr_index == CSR_MSTATUS) begin
      mstatus_mie  <= wdata[3];
      mstatus_mpie <= wdata[7];
    end
  end

  // trap-state registers, loaded by trap entry or by CSR writes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mepc_q   <= 32'd0;
      mcause_q <= 32'd0;
      mtval_q  <= 32'd0;
    end else if (trap) begin
      mepc_q   <= {i_pc[31:2], 2'b00};
      mcause_q <= {trap_is_irq, 26'd0, trap_cause};
      mtval_q  <= (exc_valid && exc_cause == EXC_BREAKPOINT) ? i_pc : 32'd0;
    end else if (csr_we) begin
      if (i_csr_index == CSR_MEPC)   mepc_q   <= {wdata[31:2], 2'b00};
      if (i_csr_index == CSR_MCAUSE) mcause_q <= wdata;
      if (i_csr_index == CSR_MTVAL)  mtval_q  <= wdata;
    end
  end

  // software-only configuration registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mie_q      <= 32'd0;
      mtvec_q    <= RESET_MTVEC;
      mscratch_q <= 32'd0;
    end else if (csr_we) begin
      if (i_csr_index == CSR_MIE)      mie_q      <= wdata & MIE_MASK;
      if (i_csr_index == CSR_MTVEC)    mtvec_q    <= {wdata[31:2], 1'b0, wdata[0]};
      if (i_csr_index == CSR_MSCRATCH) mscratch_q <= wdata;
    end
  end

  // registered outputs toward writeback and fetch
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_csr_out            <= 32'd0;
      o_trap_address       <= 32'd0;
      o_go_to_trap_q       <= 1'b0;
      o_return_from_trap_q <= 1'b0;
    end else begin
      o_go_to_trap_q       <= trap;
      o_return_from_trap_q <= mret;
      if (trap)   o_trap_address <= trap_target;
      if (commit) o_csr_out      <= rdata;
    end
  end

endmodule
